// File: rtl/matrix_mult_seq.sv
// Sequential NxN integer matrix multiplier (C = A x B), one multiply-accumulate per clock.
// Build option: define MATMUL_SIGNED_EN for two's-complement operands and results (default unsigned).
module matrix_mult_seq #(
    parameter int N  = 2,
    parameter int DW = 4,
    parameter int CW = 8,
    localparam int RW = 2*DW + $clog2(N)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [N*N*DW-1:0] matrix_A,
    input  logic [N*N*DW-1:0] matrix_B,
    output logic              busy,
    output logic              done,
    output logic [N*N*RW-1:0] matrix_result,
    output logic [CW-1:0]     matrix_count
);
    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [N*N*DW-1:0]   a_q, b_q;
    logic [IW-1:0]       i_q, j_q, k_q;
    logic [N*N*RW-1:0]   w_q, result_q;
    logic                busy_q, done_q;
    logic [CW-1:0]       count_q;
    int                  a_idx, b_idx, w_idx;

`ifdef MATMUL_SIGNED_EN
    logic signed [DW-1:0] a_el, b_el;
    logic signed [RW-1:0] a_ext, b_ext, prod_d, acc_q, acc_d;
`else
    logic        [DW-1:0] a_el, b_el;
    logic        [RW-1:0] a_ext, b_ext, prod_d, acc_q, acc_d;
`endif

    // Operand element selection and MAC datapath for the current (i,j,k)
    always_comb begin
        a_idx = int'(i_q) * N + int'(k_q);
        b_idx = int'(k_q) * N + int'(j_q);
        w_idx = int'(i_q) * N + int'(j_q);
        a_el  = a_q[a_idx*DW +: DW];
        b_el  = b_q[b_idx*DW +: DW];
`ifdef MATMUL_SIGNED_EN
        a_ext = {{(RW-DW){a_el[DW-1]}}, a_el};
        b_ext = {{(RW-DW){b_el[DW-1]}}, b_el};
`else
        a_ext = {{(RW-DW){1'b0}}, a_el};
        b_ext = {{(RW-DW){1'b0}}, b_el};
`endif
        prod_d = a_ext * b_ext;
        acc_d  = acc_q + prod_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            w_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy stays high through the done cycle, then drops unless relaunched
                    busy_q <= 1'b0;
                    if (start) begin
                        a_q     <= matrix_A;
                        b_q     <= matrix_B;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (k_q == LAST) begin
                        w_q[w_idx*RW +: RW] <= acc_d;
                        acc_q <= '0;
                        k_q   <= '0;
                        if (j_q == LAST) begin
                            j_q <= '0;
                            if (i_q == LAST) begin
                                i_q     <= '0;
                                state_q <= DONE;
                            end else begin
                                i_q <= i_q + IW'(1);
                            end
                        end else begin
                            j_q <= j_q + IW'(1);
                        end
                    end else begin
                        acc_q <= acc_d;
                        k_q   <= k_q + IW'(1);
                    end
                end
                DONE: begin
                    result_q <= w_q;
                    done_q   <= 1'b1;
                    count_q  <= count_q + CW'(1);
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign matrix_result = result_q;
    assign matrix_count  = count_q;

endmodule
